alu_obo: RTL and testbench



---
 rtl/alu_obo_pkg.sv | 30 +++
 rtl/alu_obo_core.sv | 32 +++
 rtl/alu_obo.sv | 135 +++++++++++++
 tb/tb_alu_obo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_obo_pkg.sv
// Shared constants, function codes and sequencer states for alu_obo.
// Optional macro used by the top: ALU_OBO_BTN_SYNC_EN.
package alu_obo_pkg;

  localparam int DATA_W  = 16;
  localparam int OP_W    = 2 * DATA_W;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_NOT = 4'd5;
  localparam logic [3:0] F_SLA = 4'd6;
  localparam logic [3:0] F_SRA = 4'd7;
  localparam logic [3:0] F_SRL = 4'd8;

  typedef enum logic [2:0] {
    S_A_LO   = 3'd0,
    S_A_HI   = 3'd1,
    S_B_LO   = 3'd2,
    S_B_HI   = 3'd3,
    S_SHAMT  = 3'd4,
    S_FUNCT  = 3'd5,
    S_OUT_LO = 3'd6,
    S_OUT_HI = 3'd7
  } state_t;

endpackage

// File: rtl/alu_obo_core.sv
// Combinational 32-bit ALU: a, b, shamt, funct -> result.
// Unused function codes yield zero.
module alu_obo_core
  import alu_obo_pkg::*;
#(
  parameter int OP_W    = alu_obo_pkg::OP_W,
  parameter int SHAMT_W = alu_obo_pkg::SHAMT_W
) (
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         funct,
  output logic [OP_W-1:0]    result
);

  always_comb begin
    result = '0;
    case (funct)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_XOR:   result = a ^ b;
      F_NOT:   result = ~a;
      F_SLA:   result = a << shamt;
      F_SRA:   result = $unsigned($signed(a) >>> shamt);
      F_SRL:   result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_obo.sv
// One-by-one entry ALU behind a switch bank and a single push-button.
// Define ALU_OBO_BTN_SYNC_EN to pass btn through a 2-flop synchronizer.
module alu_obo
  import alu_obo_pkg::*;
#(
  parameter int DATA_W  = alu_obo_pkg::DATA_W,
  parameter int SHAMT_W = alu_obo_pkg::SHAMT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              btn,
  output logic [DATA_W-1:0] out
);

  localparam int OW = 2 * DATA_W;

  logic              btn_s;
  logic              btn_q;
  logic              press;
  state_t            state_q, state_d;
  logic [OW-1:0]     a_q, a_d;
  logic [OW-1:0]     b_q, b_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [3:0]        funct_q, funct_d;
  logic [OW-1:0]     result_q, result_d;
  logic [OW-1:0]     alu_res;
  logic [DATA_W-1:0] out_q, out_d;

`ifdef ALU_OBO_BTN_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn;
`endif

  assign press = btn_s & ~btn_q;

  alu_obo_core #(
    .OP_W    (OW),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .shamt  (shamt_q),
    .funct  (funct_d),
    .result (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    shamt_d  = shamt_q;
    funct_d  = funct_q;
    result_d = result_q;
    if (press) begin
      case (state_q)
        S_A_LO: begin
          a_d[DATA_W-1:0] = in;
          state_d = S_A_HI;
        end
        S_A_HI: begin
          a_d[OW-1:DATA_W] = in;
          state_d = S_B_LO;
        end
        S_B_LO: begin
          b_d[DATA_W-1:0] = in;
          state_d = S_B_HI;
        end
        S_B_HI: begin
          b_d[OW-1:DATA_W] = in;
          state_d = S_SHAMT;
        end
        S_SHAMT: begin
          shamt_d = in[SHAMT_W-1:0];
          state_d = S_FUNCT;
        end
        S_FUNCT: begin
          funct_d = in[3:0];
          state_d = S_OUT_LO;
        end
        S_OUT_LO: state_d = S_OUT_HI;
        default:  state_d = S_A_LO;
      endcase
    end
    // ALU sees the function code being latched this edge
    if (press && state_q == S_FUNCT) result_d = alu_res;
  end

  always_comb begin
    out_d = '0;
    case (state_d)
      S_OUT_LO: out_d = result_d[DATA_W-1:0];
      S_OUT_HI: out_d = result_d[OW-1:DATA_W];
      default:  out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q    <= 1'b0;
      state_q  <= S_A_LO;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      funct_q  <= '0;
      result_q <= '0;
      out_q    <= '0;
    end else begin
      btn_q    <= btn_s;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shamt_q  <= shamt_d;
      funct_q  <= funct_d;
      result_q <= result_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu_obo.sv
// Scoreboard bench for alu_obo: expected display values queued per press.
// Works with or without ALU_OBO_BTN_SYNC_EN.
module tb_alu_obo;

  logic        clk;
  logic        rst;
  logic [15:0] in_sw;
  logic        btn;
  logic [15:0] out;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  alu_obo dut (
    .clk (clk),
    .rst (rst),
    .in  (in_sw),
    .btn (btn),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [4:0] sh,
                                        input logic [3:0] f);
    logic [31:0] r;
    case (f)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: begin
        r = a >> sh;
        for (int i = 0; i < 32; i++)
          if (a[31] && i >= 32 - int'(sh)) r[i] = 1'b1;
      end
      4'd8: r = a >> sh;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic press(input string tag, input logic [15:0] v,
                       input logic [15:0] exp, input int hold = 1);
    @(negedge clk);
    in_sw = v;
    btn   = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    exp_q.push_back(exp);
    repeat (4) @(negedge clk);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk(tag, {16'h0, out}, {16'h0, exp_q.pop_front()});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] sh,
                        input logic [3:0] f, input logic [31:0] r);
    press({tag, "_alo"}, a[15:0], 16'h0);
    press({tag, "_ahi"}, a[31:16], 16'h0);
    press({tag, "_blo"}, b[15:0], 16'h0);
    press({tag, "_bhi"}, b[31:16], 16'h0);
    press({tag, "_sh"}, sh, 16'h0);
    press({tag, "_lo"}, {12'h0, f}, r[15:0]);
    press({tag, "_hi"}, 16'hABCD, r[31:16]);
    press({tag, "_wrap"}, 16'h5555, 16'h0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rs;
    logic [3:0]  rf;
    rst   = 1'b1;
    in_sw = 16'h0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {16'h0, out}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("sub", 32'd200, 32'd100, 16'd0, 4'd1, 32'h0000_0064);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 16'd0, 4'd0, 32'h0);
    run_op("xor", 32'h1234_5678, 32'h0F0F_0F0F, 16'd0, 4'd4,
           32'h1D3B_5977);
    run_op("sra", 32'h8000_0000, 32'd0, 16'd4, 4'd7, 32'hF800_0000);
    run_op("srl", 32'h8000_0000, 32'd0, 16'd4, 4'd8, 32'h0800_0000);
    run_op("sla", 32'd1, 32'd0, 16'd31, 4'd6, 32'h8000_0000);
    run_op("not", 32'h0000_00FF, 32'h1234, 16'd0, 4'd5, 32'hFFFF_FF00);
    run_op("f9", 32'hDEAD_BEEF, 32'h1, 16'd0, 4'd9, 32'h0);
    run_op("shmask", 32'h8000_0000, 32'd0, 16'hFFE3, 4'd8,
           32'h1000_0000);
    run_op("and", 32'hF0F0_1234, 32'h0FF0_FF00, 16'd0, 4'd2,
           32'h00F0_1200);
    run_op("or", 32'hF000_0001, 32'h000F_0010, 16'd0, 4'd3,
           32'hF00F_0011);
    run_op("sh0", 32'hCAFE_F00D, 32'd0, 16'd0, 4'd7, 32'hCAFE_F00D);

    // held button must count as one press
    press("hold_alo", 16'd5, 16'h0, 6);
    press("hold_ahi", 16'd0, 16'h0);
    press("hold_blo", 16'd3, 16'h0);
    press("hold_bhi", 16'd0, 16'h0);
    press("hold_sh", 16'd0, 16'h0);
    press("hold_lo", 16'd0, 16'd8);
    press("hold_hi", 16'd0, 16'd0);
    press("hold_wrap", 16'd0, 16'd0);

    // reset in S_B_HI discards partial entry
    press("mid_alo", 16'h1111, 16'h0);
    press("mid_ahi", 16'h2222, 16'h0);
    press("mid_blo", 16'h3333, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", {16'h0, out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 32'h0000_0010, 32'h0000_0001, 16'd0, 4'd1,
           32'h0000_000F);

    // reset coincident with a press: press lost
    press("co_alo", 16'h0101, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b1;
    in_sw = 16'h7777;
    @(negedge clk);
    rst = 1'b0;
    btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("co_rst_out", {16'h0, out}, 32'h0);
    run_op("after_co", 32'h0001_0002, 32'h0003_0004, 16'd0, 4'd0,
           32'h0004_0006);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 5'($urandom_range(0, 31));
      rf = 4'($urandom_range(0, 10));
      run_op($sformatf("rnd%0d", k), ra, rb, {11'h0, rs}, rf,
             model(ra, rb, rs, rf));
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
